// File: rtl/rv32i_run_pkg.sv
// Shared types for the RV32I run/bring-up controller: run modes, controller
// states and the mode decode applied when a run is started.
package rv32i_run_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        COUNT = 2'd1,
        STEP  = 2'd2,
        RSVD  = 2'd3
    } run_mode_e;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RESET_HOLD = 3'd1,
        RUN        = 3'd2,
        STEP_WAIT  = 3'd3,
        DONE       = 3'd4
    } run_state_e;

    // The reserved encoding behaves exactly like a free run.
    function automatic run_mode_e decode_mode(input logic [1:0] mode_raw);
        run_mode_e m;
        case (mode_raw)
            2'd1:    m = COUNT;
            2'd2:    m = STEP;
            default: m = FREE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rv32i_run_ctrl.sv
// Run controller for the RV32I core: sequences core reset, then runs the core
// free, for a fixed number of enabled cycles, or one step at a time.
module rv32i_run_ctrl
    import rv32i_run_pkg::*;
#(
    parameter int CNT_W              = 32,
    parameter int RST_HOLD_CYCLES    = 2,
    parameter int DEFAULT_RUN_CYCLES = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic             step_req,
    input  logic             halt_req,
    output logic             core_rst,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycles_run
);

    localparam int               HOLD_W      = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(RST_HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] DEFAULT_TGT = CNT_W'(DEFAULT_RUN_CYCLES);

    run_state_e        state_q,    state_d;
    run_mode_e         mode_q,     mode_d;
    logic [CNT_W-1:0]  target_q,   target_d;
    logic [HOLD_W-1:0] hold_q,     hold_d;
    logic [CNT_W-1:0]  cycles_q,   cycles_d;
    logic              core_rst_q, core_rst_d;
    logic              core_en_q,  core_en_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic [CNT_W-1:0]  cycles_inc;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        target_d   = target_q;
        hold_d     = hold_q;
        cycles_d   = cycles_q;
        core_rst_d = core_rst_q;
        core_en_d  = core_en_q;
        busy_d     = busy_q;
        done_d     = done_q;

        // Every cycle the core was enabled is counted, whatever state follows.
        cycles_inc = (cycles_q == CNT_MAX) ? cycles_q : cycles_q + 1'b1;
        if (core_en_q) begin
            cycles_d = cycles_inc;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RESET_HOLD;
                    mode_d     = decode_mode(mode);
                    target_d   = (run_cycles == '0) ? DEFAULT_TGT : run_cycles;
                    hold_d     = HOLD_LOAD;
                    cycles_d   = '0;
                    core_rst_d = 1'b1;
                    core_en_d  = 1'b0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                end
            end
            RESET_HOLD: begin
                if (halt_req) begin
                    // core_rst stays asserted so the core is left in reset.
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (hold_q <= HOLD_LAST) begin
                    core_rst_d = 1'b0;
                    if (mode_q == STEP) begin
                        state_d = STEP_WAIT;
                    end else begin
                        state_d   = RUN;
                        core_en_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            RUN: begin
                if (halt_req || (mode_q == COUNT && cycles_inc == target_q)) begin
                    state_d   = DONE;
                    core_en_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            STEP_WAIT: begin
                core_en_d = 1'b0;
                if (halt_req) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (step_req && !core_en_q) begin
                    // A request during the enabled cycle is the re-arm slot.
                    core_en_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                core_rst_d = 1'b1;
                core_en_d  = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            mode_q     <= FREE;
            target_q   <= '0;
            hold_q     <= '0;
            cycles_q   <= '0;
            core_rst_q <= 1'b1;
            core_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            target_q   <= target_d;
            hold_q     <= hold_d;
            cycles_q   <= cycles_d;
            core_rst_q <= core_rst_d;
            core_en_q  <= core_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign core_rst   = core_rst_q;
    assign core_en    = core_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cycles_run = cycles_q;

endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// Scoreboard bench for rv32i_run_ctrl: each run pushes its expected summary,
// a monitor measures the run from the outputs and compares when done rises.
module tb_rv32i_run_ctrl;

    localparam int W    = 8;
    localparam int H    = 2;
    localparam int DEF  = 30;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [W-1:0] run_cycles = '0;
    logic         step_req = 1'b0;
    logic         halt_req = 1'b0;
    logic         core_rst, core_en, busy, done;
    logic [W-1:0] cycles_run;

    rv32i_run_ctrl #(
        .CNT_W(W),
        .RST_HOLD_CYCLES(H),
        .DEFAULT_RUN_CYCLES(DEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .mode(mode),
        .run_cycles(run_cycles),
        .step_req(step_req),
        .halt_req(halt_req),
        .core_rst(core_rst),
        .core_en(core_en),
        .busy(busy),
        .done(done),
        .cycles_run(cycles_run)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hold;
        int en;
        int pulses;
        int cyc;
        int rst_done;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endfunction

    // Monitor: measures each run from the outputs alone.
    initial begin
        int   hold_cnt, en_cnt, pulse_cnt;
        logic pbusy, pdone, pen;
        exp_t e;
        hold_cnt = 0; en_cnt = 0; pulse_cnt = 0;
        pbusy = 1'b0; pdone = 1'b0; pen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (busy && !pbusy) begin
                    hold_cnt = 0; en_cnt = 0; pulse_cnt = 0;
                    check("start_done_clear", int'(done), 0);
                    check("start_core_rst", int'(core_rst), 1);
                end
                if (busy && core_rst) hold_cnt++;
                if (core_en) en_cnt++;
                if (core_en && !pen) pulse_cnt++;
                if (done && !pdone) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        $display("run done: cycles_run=%0d en=%0d pulses=%0d hold=%0d core_rst=%0d",
                                 cycles_run, en_cnt, pulse_cnt, hold_cnt, core_rst);
                        check("cycles_run", int'(cycles_run), e.cyc);
                        check("en_cycles", en_cnt, e.en);
                        check("en_pulses", pulse_cnt, e.pulses);
                        check("hold_cycles", hold_cnt, e.hold);
                        check("done_core_rst", int'(core_rst), e.rst_done);
                        check("done_core_en", int'(core_en), 0);
                        check("done_busy", int'(busy), 0);
                    end
                end
            end
            pbusy = busy; pdone = done; pen = core_en;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && sb_q.size() != 0; i++) tick(1);
        if (sb_q.size() != 0) begin
            check("run_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        tick($urandom_range(0, 2));
    endtask

    // hc: cycle after start in which halt_req is high (0 = none).
    // sc: cycle after start carrying a start pulse that must be ignored (0 = none).
    task automatic run_xfer(input int m, input int rc, input int hc, input int sc);
        exp_t e;
        int   eff, k, last;
        eff = (rc == 0) ? DEF : rc;
        if (hc > 0 && hc <= H) begin
            e.hold = hc; e.en = 0; e.rst_done = 1;
        end else begin
            e.hold = H; e.rst_done = 0;
            k = hc - H;
            if (m == 1) e.en = (hc > 0 && k < eff) ? k : eff;
            else        e.en = k;
        end
        e.pulses = (e.en > 0) ? 1 : 0;
        e.cyc    = (e.en > MAXV) ? MAXV : e.en;
        sb_q.push_back(e);
        mode = 2'(m); run_cycles = W'(rc); start = 1'b1;
        tick(1);
        last = (hc > sc) ? hc : sc;
        for (int c = 1; c <= last; c++) begin
            start = (c == sc);
            if (c == sc) begin
                mode = 2'($urandom); run_cycles = W'($urandom);
            end
            halt_req = (c == hc);
            tick(1);
        end
        start = 1'b0; halt_req = 1'b0;
        wait_done();
    endtask

    // Bursts of held step_req, each separated by at least two idle cycles.
    task automatic step_xfer(input int nb, input int max_len, input int final_step);
        exp_t e;
        int   gap[8], len[8], p;
        p = 0;
        for (int b = 0; b < nb; b++) begin
            gap[b] = $urandom_range(2, 4);
            len[b] = $urandom_range(1, max_len);
            p += (len[b] + 1) / 2;
        end
        e.hold = H; e.en = p; e.pulses = p; e.cyc = p; e.rst_done = 0;
        sb_q.push_back(e);
        mode = 2'd2; run_cycles = W'($urandom); start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(H);
        for (int b = 0; b < nb; b++) begin
            tick(gap[b]);
            step_req = 1'b1;
            tick(len[b]);
            step_req = 1'b0;
        end
        tick($urandom_range(2, 4));
        halt_req = 1'b1; step_req = final_step[0];
        tick(1);
        halt_req = 1'b0; step_req = 1'b0;
        wait_done();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_core_rst"}, int'(core_rst), 1);
        check({tag, "_core_en"}, int'(core_en), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_cycles_run"}, int'(cycles_run), 0);
    endtask

    initial begin
        int kind, m, rc, hc, sc, eff;
        rst = 1'b0;
        tick(3);
        check_idle_outputs("reset");
        rst = 1'b1;
        tick(5);
        check_idle_outputs("idle");

        run_xfer(1, 0, 0, 0);          // default-length count
        run_xfer(1, 100, H + 10, 0);   // halt on 10th enabled cycle
        step_xfer(3, 1, 1);            // isolated steps, then step+halt
        run_xfer(0, 0, H + 50, 0);     // free run of 50
        run_xfer(1, 5, 0, 0);          // restart from done
        run_xfer(1, MAXV, 0, 0);       // all-ones target
        run_xfer(0, 0, H + 300, 0);    // saturation
        run_xfer(1, 10, 1, 0);         // halt in reset hold
        run_xfer(3, 0, H, 0);          // halt on last hold cycle, reserved mode
        run_xfer(1, 8, 0, H + 3);      // start during run ignored
        step_xfer(2, 4, 0);            // held step_req

        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    rc  = $urandom_range(0, 40);
                    eff = (rc == 0) ? DEF : rc;
                    hc  = $urandom_range(0, 1) ? 0 : $urandom_range(1, H + 45);
                    sc  = (hc == 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, H + eff) : 0;
                    run_xfer(1, rc, hc, sc);
                end
                1: begin
                    m  = $urandom_range(0, 1) ? 0 : 3;
                    hc = $urandom_range(H + 1, H + 60);
                    sc = $urandom_range(0, 1) ? $urandom_range(1, hc - 1) : 0;
                    run_xfer(m, $urandom_range(0, 255), hc, sc);
                end
                2: step_xfer($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 1));
                default: run_xfer($urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(1, H), 0);
            endcase
        end

        // Reset in the middle of a run aborts straight back to idle values.
        mode = 2'd1; run_cycles = W'(100); start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(H + 5);
        rst = 1'b0;
        tick(1);
        check_idle_outputs("midrun_reset");
        rst = 1'b1;
        tick(3);
        check_idle_outputs("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rv32i_run_ctrl.md
Name: rv32i_run_ctrl

Overview:
- Hardware run/bring-up controller for the RV32I core.
- Sequences the core reset, then runs the core in one of three modes: free-run, a fixed cycle count, or single-step.
- Drives the core's reset and clock-enable, counts enabled cycles, and raises a sticky done flag.
- Sits between board/debug control and RV32I_TOP, replacing fixed cycle-count sequencing with a parametrised, synthesizable controller.

Parameters:
- CNT_W, 32, width of cycle counters and run_cycles.
- RST_HOLD_CYCLES, 2, number of cycles core_rst is held high after start (minimum 1).
- DEFAULT_RUN_CYCLES, 30, run length used in COUNT mode when run_cycles==0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets the block on a rising clk edge).
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- mode  in  2  0=FREE, 1=COUNT, 2=STEP, 3=reserved (treated as FREE); sampled only when start is accepted.
- run_cycles  in  CNT_W  COUNT-mode target; sampled only when start is accepted.
- step_req  in  1  STEP mode: request one enabled core cycle.
- halt_req  in  1  stop the run; has priority over every other request except rst.
- core_rst  out  1  active-high reset to the core.
- core_en  out  1  clock-enable to the core.
- busy  out  1  high in RESET_HOLD, RUN and STEP_WAIT.
- done  out  1  sticky; high in DONE.
- cycles_run  out  CNT_W  count of cycles with core_en==1 in the current run; saturates at all-ones.

Behaviour:
- All outputs are registered.
- Reset values (rst==0): state=IDLE, core_rst=1, core_en=0, busy=0, done=0, cycles_run=0. Reset mid-run aborts immediately, with no drain.
- IDLE:
  - core_rst=1, core_en=0.
  - start → latch mode and target; target = (run_cycles==0 ? DEFAULT_RUN_CYCLES : run_cycles).
  - Load hold counter = RST_HOLD_CYCLES, clear cycles_run, go to RESET_HOLD.
  - halt_req and step_req are ignored; start in the same cycle as halt_req is accepted.
- RESET_HOLD:
  - core_rst=1, core_en=0, busy=1.
  - Hold counter decrements each cycle; core_rst is high for exactly RST_HOLD_CYCLES cycles after start is accepted.
  - At 0: go to RUN (FREE/COUNT) or STEP_WAIT (STEP).
  - halt_req goes to DONE, with core_rst remaining 1 in DONE for this path.
- RUN:
  - core_rst=0, core_en=1; cycles_run increments every cycle core_en==1.
  - COUNT: exactly target cycles with core_en==1. When cycles_run will reach target on this cycle, go to DONE; core_en is 0 the following cycle.
  - FREE: runs until halt_req.
  - halt_req: core_en=0 from the next cycle; the cycle in which halt_req is sampled still has core_en at its registered value.
- STEP_WAIT:
  - core_rst=0, core_en=0 by default.
  - step_req → core_en=1 for exactly one cycle, the next cycle; cycles_run += 1.
  - step_req held high produces one enable every other cycle (enable, then re-arm).
  - step_req together with halt_req: halt wins and no enable is produced.
- DONE:
  - done=1, busy=0, core_en=0; core_rst holds its last value so core state stays inspectable.
  - cycles_run is frozen.
  - start → new run, same as from IDLE; done clears on entry to RESET_HOLD.
- start while busy: ignored.
- cycles_run saturates at 2^CNT_W−1 (FREE mode); it does not wrap.
- Counter widths: all comparisons are on CNT_W bits; target is unsigned.

Decomposition:
- Package rv32i_run_pkg:
  - typedef enum logic[1:0] run_mode_e {FREE, COUNT, STEP, RSVD}.
  - typedef enum logic[2:0] run_state_e {IDLE, RESET_HOLD, RUN, STEP_WAIT, DONE}.
- Single module; no sub-module. The saturating counter is inline.
- Integration wrapper ties core_rst/core_en into RV32I_TOP; the wrapper is not part of this block.

Test Plan:
- Reset: rst=0 for 3 cycles → core_rst=1, core_en=0, busy=0, done=0, cycles_run=0. Release, then idle for 5 cycles → outputs unchanged.
- COUNT with defaults: start, mode=1, run_cycles=0 → core_rst high for 2 cycles, then core_en high for exactly 30 cycles. Then done=1, cycles_run=30, core_en=0.
- COUNT with explicit target plus halt: start, mode=1, run_cycles=100, halt_req pulsed on the 10th enabled cycle → core_en=0 the next cycle, done=1, cycles_run=10 (±0 vs the sampled edge checked exactly).
- STEP: start, mode=2; 3 isolated step_req pulses → exactly 3 single-cycle core_en pulses, cycles_run=3. step_req+halt_req in the same cycle → no pulse, done=1, cycles_run=3.
- FREE plus restart: start, mode=0, run 50 cycles, halt → cycles_run=50. Then start, mode=1, run_cycles=5 → done clears, core_rst reasserts for 2 cycles, 5 enabled cycles, cycles_run=5.
- Reset mid-run and ignored start: start while in RUN → no effect. rst=0 during RUN → next edge gives IDLE values (core_rst=1, core_en=0, cycles_run=0).
